// File: rtl/rsff_chk_pkg.sv
// rsff_chk_pkg: shared state encoding, LFSR polynomial and seed for the RSFF stimulus checker.
`default_nettype none

package rsff_chk_pkg;

   typedef logic [1:0] state_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRIVE = 2'd1;
   localparam logic [1:0] ST_CHECK = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // x^16+x^14+x^13+x^11+1 as a right-shifting Fibonacci register: taps at bits 0,2,3,5
   localparam logic [15:0] LFSR_TAPS    = 16'h002D;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {^(s & LFSR_TAPS), s[15:1]};
   endfunction

endpackage

`default_nettype wire

// File: rtl/rsff_stim_chk_if.sv
// rsff_stim_chk_if: control/status and flop-under-test signals of the RSFF stimulus checker.
`default_nettype none

interface rsff_stim_chk_if #(
   parameter int CW = 16
);
   logic          start;
   logic          dut_d;
   logic          dut_reset;
   logic          dut_set_n;
   logic          dut_q;
   logic          busy;
   logic          done;
   logic          pass;
   logic [CW-1:0] vec_count;
   logic [CW-1:0] err_count;

   modport master (
      input  start, dut_q,
      output dut_d, dut_reset, dut_set_n, busy, done, pass, vec_count, err_count
   );

   modport slave (
      output start, dut_q,
      input  dut_d, dut_reset, dut_set_n, busy, done, pass, vec_count, err_count
   );
endinterface

`default_nettype wire

// File: rtl/rsff_chk_lfsr.sv
// rsff_chk_lfsr: 16-bit Fibonacci LFSR with synchronous load of SEED and advance enable.
`default_nettype none

module rsff_chk_lfsr
   import rsff_chk_pkg::*;
#(
   parameter logic [15:0] SEED = DEFAULT_SEED
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        advance,
   output logic [15:0] state
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= SEED;
      end else if (load) begin
         state <= SEED;
      end else if (advance) begin
         state <= lfsr_next(state);
      end
   end

endmodule

`default_nettype wire

// File: rtl/rsff_stim_chk.sv
// rsff_stim_chk: drives LFSR vectors into a negedge RS flop and checks its output (reset beats set).
// Define RSFF_CHK_STOP_ON_ERR_EN to end a run at the first mismatch.
`default_nettype none

module rsff_stim_chk
   import rsff_chk_pkg::*;
#(
   parameter int          NUM_VEC = 256,
   parameter logic [15:0] SEED    = DEFAULT_SEED,
   parameter int          CW      = 16
) (
   input  logic           clk,
   input  logic           reset,
   rsff_stim_chk_if.master bus
);

   localparam logic [CW-1:0] LAST_CNT = CW'(NUM_VEC - 1);
   localparam logic [2:0]    IDLE_VEC = 3'b110;

   logic [1:0]    state;
   logic [15:0]   lfsr;
   logic [CW-1:0] vec_count;
   logic [CW-1:0] err_count;
   logic          dut_d;
   logic          dut_reset;
   logic          dut_set_n;
   logic          start_ok;
   logic          advance;
   logic          expected;
   logic          mismatch;
   logic          last;
   logic          stop;

   // Vector packing is {dut_reset, dut_set_n, dut_d}
   function automatic logic [2:0] stim_vec(input logic [15:0] s);
      return {(s[3:2] == 2'b00), (s[5:4] != 2'b00), s[0]};
   endfunction

   assign start_ok = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
   assign advance  = (state == ST_DRIVE);
   assign expected = dut_reset ? 1'b0 : (!dut_set_n ? 1'b1 : dut_d);
   assign mismatch = (bus.dut_q != expected);
   assign last     = (vec_count == LAST_CNT);

`ifdef RSFF_CHK_STOP_ON_ERR_EN
   assign stop = last || mismatch;
`else
   assign stop = last;
`endif

   rsff_chk_lfsr #(
      .SEED (SEED)
   ) u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .load    (start_ok),
      .advance (advance),
      .state   (lfsr)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state                           <= ST_IDLE;
         vec_count                       <= '0;
         err_count                       <= '0;
         {dut_reset, dut_set_n, dut_d}   <= IDLE_VEC;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  // LFSR register loads SEED this edge, so the first vector decodes SEED directly
                  state                         <= ST_DRIVE;
                  vec_count                     <= '0;
                  err_count                     <= '0;
                  {dut_reset, dut_set_n, dut_d} <= stim_vec(SEED);
               end
            end
            ST_DRIVE: begin
               state <= ST_CHECK;
            end
            default: begin
               vec_count <= vec_count + CW'(1);
               if (mismatch && (err_count != '1)) begin
                  err_count <= err_count + CW'(1);
               end
               if (stop) begin
                  state                         <= ST_DONE;
                  {dut_reset, dut_set_n, dut_d} <= IDLE_VEC;
               end else begin
                  state                         <= ST_DRIVE;
                  {dut_reset, dut_set_n, dut_d} <= stim_vec(lfsr);
               end
            end
         endcase
      end
   end

   assign bus.dut_d     = dut_d;
   assign bus.dut_reset = dut_reset;
   assign bus.dut_set_n = dut_set_n;
   assign bus.busy      = (state == ST_DRIVE) || (state == ST_CHECK);
   assign bus.done      = (state == ST_DONE);
   assign bus.pass      = (state == ST_DONE) && (err_count == '0);
   assign bus.vec_count = vec_count;
   assign bus.err_count = err_count;

endmodule

`default_nettype wire

// File: tb/tb_rsff_stim_chk.sv
// tb_rsff_stim_chk: directed runs of rsff_stim_chk against a behavioural RS flop and a reference model.
`default_nettype none

module tb_rsff_stim_chk;

   localparam int N  = 256;
   localparam int SN = 15;

   logic       clk = 1'b0;
   logic       reset;
   int         mode;
   int         n_tests = 0;
   int         n_fail  = 0;
   logic       flop_q;
   logic [15:0] seq [N];
   logic [2:0]  first_run [N];

   always #5 clk = ~clk;

   rsff_stim_chk_if #(.CW(16)) bus ();
   rsff_stim_chk_if #(.CW(4))  sbus ();

   rsff_stim_chk #(.NUM_VEC(N), .SEED(16'hACE1), .CW(16)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   rsff_stim_chk #(.NUM_VEC(SN), .SEED(16'hACE1), .CW(4)) u_dut_small (
      .clk   (clk),
      .reset (reset),
      .bus   (sbus)
   );

   // Negedge RS flop, reset dominant over set
   always @(negedge clk or posedge bus.dut_reset or negedge bus.dut_set_n) begin
      if (bus.dut_reset)       flop_q <= 1'b0;
      else if (!bus.dut_set_n) flop_q <= 1'b1;
      else                     flop_q <= bus.dut_d;
   end

   assign bus.dut_q  = (mode == 0) ? flop_q : ((mode == 1) ? 1'b0 : 1'b1);
   assign sbus.dut_q = ~(sbus.dut_reset ? 1'b0 : (!sbus.dut_set_n ? 1'b1 : sbus.dut_d));

   function automatic logic [15:0] poly_step(input logic [15:0] s);
      int   exps [4];
      logic fb;
      exps = '{16, 14, 13, 11};
      fb   = 1'b0;
      for (int k = 0; k < 4; k++) fb ^= s[16 - exps[k]];
      return {fb, s[15:1]};
   endfunction

   function automatic logic [2:0] stim(input int i);
      logic [15:0] v;
      v = seq[i];
      return {(v[3:2] == 2'b00), !(v[5:4] == 2'b00), v[0]};
   endfunction

   function automatic logic exp_q(input int i);
      logic [2:0] s;
      s = stim(i);
      if (s[2])      return 1'b0;
      else if (!s[1]) return 1'b1;
      else           return s[0];
   endfunction

   function automatic bit miss(input int md, input int i);
      if (md == 1) return exp_q(i) == 1'b1;
      if (md == 2) return exp_q(i) == 1'b0;
      return 1'b0;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ctl"}, {bus.busy, bus.done, bus.pass}, 3'b000);
      check({tag, "_vec"}, {bus.dut_reset, bus.dut_set_n, bus.dut_d}, 3'b110);
      check({tag, "_cnt"}, {bus.vec_count, bus.err_count}, 32'd0);
   endtask

   // rec: 1 = record stream, 2 = compare stream against recorded one
   task automatic run(input int md, input bit hold, input int abort_at, input int rec);
      int         nv;
      int         errs;
      logic [2:0] obs;
      mode = md;
      nv   = N;
`ifdef RSFF_CHK_STOP_ON_ERR_EN
      for (int i = 0; i < N; i++) begin
         if (miss(md, i)) begin
            nv = i + 1;
            break;
         end
      end
`endif
      errs = 0;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) bus.start = 1'b0;
      for (int c = 0; c < 2 * nv; c++) begin
         int i;
         i   = c / 2;
         obs = {bus.dut_reset, bus.dut_set_n, bus.dut_d};
         if (rec == 1 && c % 2 == 0) first_run[i] = obs;
         if (rec == 2 && c % 2 == 0) check("rerun_vs_first", obs, first_run[i]);
         check("run_ctl", {bus.busy, bus.done, bus.pass}, 3'b100);
         check("run_vec", obs, stim(i));
         check("run_cnt", {bus.vec_count, bus.err_count}, {16'(i), 16'(errs)});
         if (c == 2 * abort_at) begin
            reset = 1'b0;
            #1;
            check_idle("abort");
            @(negedge clk);
            reset     = 1'b1;
            bus.start = 1'b0;
            return;
         end
         if (c % 2 == 1 && miss(md, i)) errs++;
         @(posedge clk);
         #1;
      end
      check("done_ctl", {bus.busy, bus.done, bus.pass}, {2'b01, (errs == 0)});
      check("done_vec", {bus.dut_reset, bus.dut_set_n, bus.dut_d}, 3'b110);
      check("done_cnt", {bus.vec_count, bus.err_count}, {16'(nv), 16'(errs)});
      if (hold) bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("hold_ctl", {bus.busy, bus.done, bus.pass}, {2'b01, (errs == 0)});
      check("hold_cnt", {bus.vec_count, bus.err_count}, {16'(nv), 16'(errs)});
   endtask

   task automatic small_run();
      int cyc;
      int exp_nv;
      exp_nv = SN;
`ifdef RSFF_CHK_STOP_ON_ERR_EN
      exp_nv = 1;
`endif
      @(negedge clk);
      sbus.start = 1'b1;
      @(posedge clk);
      #1;
      sbus.start = 1'b0;
      cyc = 0;
      while (!sbus.done && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("small_latency", cyc, 2 * exp_nv);
      check("small_cnt", {sbus.vec_count, sbus.err_count}, {4'(exp_nv), 4'(exp_nv)});
      check("small_pass", sbus.pass, 1'b0);
   endtask

   initial begin
      reset      = 1'b1;
      mode       = 0;
      bus.start  = 1'b0;
      sbus.start = 1'b0;
      seq[0]     = 16'hACE1;
      for (int i = 1; i < N; i++) seq[i] = poly_step(seq[i-1]);
      #2 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_idle("reset");
      check("small_reset_ctl", {sbus.busy, sbus.done, sbus.pass}, 3'b000);
      check("small_reset_cnt", {sbus.vec_count, sbus.err_count}, 8'd0);
      @(negedge clk);
      reset = 1'b1;

      run(0, 1'b0, -1, 1);
      run(1, 1'b0, -1, 0);
      run(0, 1'b1, -1, 0);
      run(0, 1'b0, 100, 0);
      run(0, 1'b0, -1, 2);
`ifdef RSFF_CHK_STOP_ON_ERR_EN
      run(2, 1'b0, -1, 0);
`endif
      small_run();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rsff_stim_chk.md
RSFF_STIM_CHK -- requirements
Module: rsff_stim_chk

Interface
- REQ-001 The module SHALL have parameter NUM_VEC, default 256: number of vectors per run (1..2**CW-1).
- REQ-002 The module SHALL have parameter SEED, default 16'hACE1: LFSR load value; nonzero.
- REQ-003 The module SHALL have parameter CW, default 16: width of vec_count and err_count.
- REQ-004 clk  in  1  single clock; all state updates on posedge.
- REQ-005 reset  in  1  asynchronous, active-low; assertion clears all state immediately.
- REQ-006 start  in  1  begins a run when sampled high in IDLE or DONE.
- REQ-007 dut_d  out  1  data to the flop under test.
- REQ-008 dut_reset  out  1  active-high async reset to the flop under test.
- REQ-009 dut_set_n  out  1  active-low async set to the flop under test.
- REQ-010 dut_q  in  1  flop-under-test output; the flop under test captures on negedge clk.
- REQ-011 busy  out  1  high in DRIVE/CHECK.
- REQ-012 done  out  1  high in DONE.
- REQ-013 pass  out  1  high in DONE when err_count==0.
- REQ-014 vec_count  out  CW  vectors checked this run.
- REQ-015 err_count  out  CW  mismatches this run, saturating.

Function
- REQ-016 FSM states SHALL be IDLE, DRIVE, CHECK, DONE.
- REQ-017 In IDLE/DONE the outputs SHALL be dut_reset=1, dut_set_n=1, dut_d=0, holding the flop under test at q=0.
- REQ-018 start in IDLE/DONE SHALL load the LFSR with SEED, clear both counters, and enter DRIVE.
- REQ-019 start in DRIVE/CHECK SHALL be ignored.
- REQ-020 Each vector SHALL be taken from the 16-bit Fibonacci LFSR x^16+x^14+x^13+x^11+1: dut_d=lfsr[0]; dut_reset=(lfsr[3:2]==0); dut_set_n=!(lfsr[5:4]==0).
- REQ-021 Vector outputs SHALL be registered and change only on entry to DRIVE.
- REQ-022 The LFSR SHALL advance once per vector.
- REQ-023 DRIVE SHALL last one cycle and then go to CHECK; the flop under test captures at the intervening negedge.
- REQ-024 In CHECK, expected = 0 if dut_reset, else 1 if !dut_set_n, else dut_d, so reset has priority over set.
- REQ-025 CHECK SHALL compare dut_q with expected at the posedge, increment vec_count, and increment err_count on mismatch, saturating at all-ones.
- REQ-026 From CHECK, the FSM SHALL go to DRIVE if vec_count+1 < NUM_VEC, else to DONE.
- REQ-027 Latency: done SHALL rise exactly 2*NUM_VEC cycles after the start edge.
- REQ-028 DONE SHALL hold counters and pass until the next start or reset.

Reset
- REQ-029 Asserting reset SHALL force, asynchronously: state=IDLE, lfsr=SEED, counters=0, busy=0, done=0, pass=0, dut_reset=1, dut_set_n=1, dut_d=0.
- REQ-030 Reset asserted mid-run SHALL abort the run; the next start SHALL replay the identical vector sequence.

Configuration
- REQ-031 With RSFF_CHK_STOP_ON_ERR_EN defined, the first mismatch in CHECK SHALL go to DONE after updating the counters, so vec_count = index of the failing vector + 1.
- REQ-032 Without RSFF_CHK_STOP_ON_ERR_EN, all NUM_VEC vectors SHALL always run.

Structure
- REQ-033 Package rsff_chk_pkg SHALL hold the state enum, the LFSR tap mask, and the default SEED.
- REQ-034 Sub-module rsff_chk_lfsr SHALL implement a 16-bit LFSR with load and advance enables; all other logic stays in rsff_stim_chk.

Verification
- REQ-035 Behavioural negedge RSFF (reset priority) attached, NUM_VEC=256, start pulse -> done 512 cycles later, pass=1, err_count=0, vec_count=256.
- REQ-036 dut_q tied 0 -> err_count equals the bench-model count of expected-1 vectors, pass=0, vec_count=256.
- REQ-037 RSFF_CHK_STOP_ON_ERR_EN defined, dut_q tied 1 -> DONE after the first expected-0 vector, err_count=1, vec_count=that index+1.
- REQ-038 reset pulsed low during vector 100, then start -> all outputs at reset values immediately; rerun vector stream identical to the first run from vector 0.
- REQ-039 start held high for an entire run -> single run only (ignored while busy); next start in DONE -> counters cleared and a new 512-cycle run.
- REQ-040 CW=4, NUM_VEC=15, dut_q stuck at the wrong value -> err_count saturates at 15, pass=0.
